// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit Gray-to-binary converter
// between NUM_REQ requesters; the result is registered and tagged with the requester id.
module gray_conv_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_gray,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_binary,
    output logic [$clog2(NUM_REQ)-1:0]    out_id,
    output logic                          busy,
    output logic [CNT_W-1:0]              done_cnt
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     last_grant_reg;
    logic [ID_W-1:0]     id_reg;
    logic [DATA_W-1:0]   gray_reg;
    logic [DATA_W-1:0]   out_binary_reg;
    logic [ID_W-1:0]     out_id_reg;
    logic                out_valid_reg;
    logic [CNT_W-1:0]    done_cnt_reg;

    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic [DATA_W-1:0]   sel_gray;
    logic [DATA_W-1:0]   conv_bin;

    // Each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_conv
            assign conv_bin[gi] = ^gray_reg[DATA_W-1:gi];
        end
    endgenerate

    // Search starts one past the previous winner and wraps modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int              c_int;
            logic [ID_W-1:0] cand;
            c_int = int'(last_grant_reg) + k;
            if (c_int >= NUM_REQ) begin
                c_int = c_int - NUM_REQ;
            end
            cand = ID_W'(c_int);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign sel_gray = req_gray[grant_idx*DATA_W +: DATA_W];

    always_comb begin
        state_next   = state_reg;
        grant_onehot = '0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    grant_onehot = NUM_REQ'(1) << grant_idx;
                    state_next   = CONV;
                end
            end
            CONV: state_next = HOLD;
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            id_reg         <= '0;
            gray_reg       <= '0;
            out_binary_reg <= '0;
            out_id_reg     <= '0;
            out_valid_reg  <= 1'b0;
            done_cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && grant_found) begin
                gray_reg       <= sel_gray;
                id_reg         <= grant_idx;
                last_grant_reg <= grant_idx;
            end
            if (state_reg == CONV) begin
                out_binary_reg <= conv_bin;
                out_id_reg     <= id_reg;
                out_valid_reg  <= 1'b1;
            end
            if (state_reg == HOLD && out_ready) begin
                out_valid_reg <= 1'b0;
                if (done_cnt_reg != '1) begin
                    done_cnt_reg <= done_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Grants are suppressed while reset is held so no requester sees an accept.
    assign req_ready  = rst_n ? grant_onehot : '0;
    assign out_valid  = out_valid_reg;
    assign out_binary = out_binary_reg;
    assign out_id     = out_id_reg;
    assign busy       = (state_reg != IDLE);
    assign done_cnt   = done_cnt_reg;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter: vector table plus hand-written multi-cycle sequences;
// a second instance with a 4-bit counter shares the stimulus to observe saturation.
module tb_gray_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_gray;
    logic        out_ready;
    logic [3:0]  req_ready, req_ready_s;
    logic        out_valid, out_valid_s;
    logic [7:0]  out_binary, out_binary_s;
    logic [1:0]  out_id, out_id_s;
    logic        busy, busy_s;
    logic [15:0] done_cnt;
    logic [3:0]  done_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    gray_conv_arbiter #(.NUM_REQ(4), .DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_gray(req_gray),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_binary(out_binary), .out_id(out_id), .busy(busy), .done_cnt(done_cnt)
    );

    gray_conv_arbiter #(.NUM_REQ(4), .DATA_W(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_gray(req_gray),
        .req_ready(req_ready_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_binary(out_binary_s), .out_id(out_id_s), .busy(busy_s), .done_cnt(done_cnt_s)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] gray;
        bit          has;
        logic [1:0]  id;
        logic [7:0]  bin;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [7:0] ref_bin(input logic [7:0] g);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = ^(g >> k);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string tag);
        check({tag, " done_cnt"}, 32'(done_cnt), 32'(exp_cnt));
        check({tag, " done_cnt_sat"}, 32'(done_cnt_s), (exp_cnt > 15) ? 32'd15 : 32'(exp_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request from IDLE through CONV and HOLD to the handshake.
    task automatic run_entry(input vec_t v);
        req_valid = v.valid;
        req_gray  = v.gray;
        out_ready = 1'b0;
        #1;
        check("req_ready", 32'(req_ready), v.has ? 32'(4'b0001 << v.id) : 32'd0);
        if (!v.has) begin
            for (int c = 0; c < 3; c++) begin
                step();
                check("idle req_ready", 32'(req_ready), 32'd0);
                check("idle busy", 32'(busy), 32'd0);
                check("idle out_valid", 32'(out_valid), 32'd0);
            end
            req_valid = '0;
            $display("txn none valid=%b", v.valid);
            return;
        end
        step();
        req_valid = '0;
        #1;
        check("conv req_ready", 32'(req_ready), 32'd0);
        check("conv busy", 32'(busy), 32'd1);
        check("conv out_valid", 32'(out_valid), 32'd0);
        step();
        check("hold out_valid", 32'(out_valid), 32'd1);
        check("hold out_binary", 32'(out_binary), 32'(v.bin));
        check("hold out_id", 32'(out_id), 32'(v.id));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt++;
        check("done out_valid", 32'(out_valid), 32'd0);
        check("done busy", 32'(busy), 32'd0);
        check_cnt("done");
        $display("txn id=%0d gray_lanes=%h bin=%h cnt=%0d", v.id, v.gray, out_binary, done_cnt);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_binary", 32'(out_binary), 32'd0);
        check("rst out_id", 32'(out_id), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check_cnt("rst");
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t v;
        int   g1, g3;

        tbl[0] = '{4'b1111, 32'h0102_0304, 1'b1, 2'd1, 8'h02};
        tbl[1] = '{4'b0001, 32'h0000_007F, 1'b1, 2'd0, 8'h55};
        tbl[2] = '{4'b1001, 32'h1000_0020, 1'b1, 2'd3, 8'h1F};
        tbl[3] = '{4'b1100, 32'h00AA_0000, 1'b1, 2'd2, 8'hCC};
        tbl[4] = '{4'b0110, 32'h00FE_8C00, 1'b1, 2'd1, 8'hF7};
        tbl[5] = '{4'b1111, 32'h99C3_1100, 1'b1, 2'd2, 8'h82};
        tbl[6] = '{4'b1111, 32'h99C3_1100, 1'b1, 2'd3, 8'hEE};
        tbl[7] = '{4'b0000, 32'h99C3_1100, 1'b0, 2'd0, 8'h00};
        tbl[8] = '{4'b1111, 32'h99C3_1100, 1'b1, 2'd0, 8'h00};

        rst_n = 1'b0; req_valid = '0; req_gray = '0; out_ready = 1'b0;
        #2;
        apply_reset();

        // First request after reset goes to requester 0.
        v = '{4'b0001, 32'h0000_000F, 1'b1, 2'd0, 8'h0A};
        run_entry(v);

        for (int i = 0; i < 9; i++) run_entry(tbl[i]);

        // All four valid with out_ready held high: grants in id order.
        apply_reset();
        req_gray  = 32'h01FF_C080;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] eb;
            eb = ref_bin(req_gray[k*8 +: 8]);
            check("rr4 req_ready", 32'(req_ready), 32'(4'b0001 << k));
            step();
            req_valid[k] = 1'b0;
            step();
            check("rr4 out_valid", 32'(out_valid), 32'd1);
            check("rr4 out_id", 32'(out_id), 32'(k));
            check("rr4 out_binary", 32'(out_binary), 32'(eb));
            step();
            exp_cnt++;
            check_cnt("rr4");
            $display("txn id=%0d bin=%h cnt=%0d", out_id, out_binary, done_cnt);
        end
        check("rr4 lane3 ref", 32'(ref_bin(8'hFF)), 32'h0000_00AA);
        out_ready = 1'b0;

        // Requesters 1 and 3 held valid after last_grant=1 alternate, starting with 3.
        v = '{4'b0010, 32'h0000_5500, 1'b1, 2'd1, 8'h66};
        run_entry(v);
        req_gray  = 32'h3300_5500;
        req_valid = 4'b1010;
        out_ready = 1'b1;
        g1 = 0; g3 = 0;
        #1;
        for (int n = 0; n < 8; n++) begin
            logic [1:0] eid;
            eid = (n % 2 == 0) ? 2'd3 : 2'd1;
            check("alt req_ready", 32'(req_ready), 32'(4'b0001 << eid));
            if (req_ready[1]) g1++;
            if (req_ready[3]) g3++;
            step();
            step();
            check("alt out_id", 32'(out_id), 32'(eid));
            check("alt out_binary", 32'(out_binary), (eid == 2'd3) ? 32'h22 : 32'h66);
            step();
            exp_cnt++;
            $display("txn id=%0d bin=%h cnt=%0d", out_id, out_binary, done_cnt);
        end
        check("alt grants1", 32'(g1), 32'd4);
        check("alt grants3", 32'(g3), 32'd4);
        check_cnt("alt");
        req_valid = '0;
        out_ready = 1'b0;

        // Stall in HOLD for 10 cycles while another requester is waiting.
        req_gray  = 32'h0000_00F0;
        req_valid = 4'b0001;
        #1;
        check("stall req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 4'b0010;
        step();
        for (int c = 0; c < 10; c++) begin
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall out_binary", 32'(out_binary), 32'hA0);
            check("stall out_id", 32'(out_id), 32'd0);
            check("stall req_ready", 32'(req_ready), 32'd0);
            check_cnt("stall");
            step();
        end
        req_valid = '0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt++;
        check("stall release", 32'(out_valid), 32'd0);
        check_cnt("stall release");
        $display("txn id=0 bin=a0 stalled cnt=%0d", done_cnt);

        // Reset during CONV drops the pending word.
        req_gray  = 32'h4200_0000;
        req_valid = 4'b1000;
        #1;
        check("midrst req_ready", 32'(req_ready), 32'b1000);
        step();
        check("midrst busy", 32'(busy), 32'd1);
        apply_reset();
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("midrst no result", 32'(out_valid), 32'd0);
            check("midrst not busy", 32'(busy), 32'd0);
        end
        v = '{4'b1111, 32'h1122_3344, 1'b1, 2'd0, 8'h78};
        run_entry(v);

        // Exhaustive sweep on requester 2; the 4-bit counter saturates along the way.
        apply_reset();
        out_ready = 1'b1;
        for (int g = 0; g < 256; g++) begin
            req_gray         = $urandom;
            req_gray[23:16]  = 8'(g);
            req_valid        = 4'b0100;
            #1;
            check("sweep req_ready", 32'(req_ready), 32'b0100);
            step();
            req_valid = '0;
            step();
            check("sweep out_binary", 32'(out_binary), 32'(ref_bin(8'(g))));
            check("sweep out_id", 32'(out_id), 32'd2);
            step();
            exp_cnt++;
            $display("txn id=2 gray=%h bin=%h cnt=%0d", 8'(g), out_binary, done_cnt);
        end
        out_ready = 1'b0;
        check_cnt("sweep");
        check("sweep total", 32'(done_cnt), 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
